// File: rtl/calendar_pkg.sv
// rtl/calendar_pkg.sv - shared calendar types and BCD constants for the date counter
package calendar_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        CHECK = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        LONG  = 2'd0,
        SHORT = 2'd1,
        FEB   = 2'd2
    } mclass_t;

    localparam logic [7:0] M_JAN = 8'h01;
    localparam logic [7:0] M_FEB = 8'h02;
    localparam logic [7:0] M_MAR = 8'h03;
    localparam logic [7:0] M_APR = 8'h04;
    localparam logic [7:0] M_MAY = 8'h05;
    localparam logic [7:0] M_JUN = 8'h06;
    localparam logic [7:0] M_JUL = 8'h07;
    localparam logic [7:0] M_AUG = 8'h08;
    localparam logic [7:0] M_SEP = 8'h09;
    localparam logic [7:0] M_OCT = 8'h10;
    localparam logic [7:0] M_NOV = 8'h11;
    localparam logic [7:0] M_DEC = 8'h12;

    localparam logic [7:0] D_01 = 8'h01;
    localparam logic [7:0] D_28 = 8'h28;
    localparam logic [7:0] D_29 = 8'h29;
    localparam logic [7:0] D_30 = 8'h30;
    localparam logic [7:0] D_31 = 8'h31;

    localparam logic [15:0] Y_MAX = 16'h9999;

    function automatic mclass_t month_class(input logic [7:0] month);
        case (month)
            M_FEB:                      return FEB;
            M_APR, M_JUN, M_SEP, M_NOV: return SHORT;
            default:                    return LONG;
        endcase
    endfunction

endpackage

// File: rtl/month_length.sv
// rtl/month_length.sv - maximum BCD day for a BCD month, February decided by the leap flag
module month_length
    import calendar_pkg::*;
(
    input  logic [7:0] i_month,
    input  logic       i_ly,
    output logic [7:0] o_len
);

    always_comb begin
        o_len = D_31;
        case (month_class(i_month))
            SHORT:   o_len = D_30;
            FEB:     o_len = i_ly ? D_29 : D_28;
            default: o_len = D_31;
        endcase
    end

endmodule

// File: rtl/bcd_date_counter.sv
// rtl/bcd_date_counter.sv - BCD year/month/day counter with validated load and Feb-29 leap check
module bcd_date_counter
    import calendar_pkg::*;
#(
    parameter logic [15:0] RST_YEAR  = 16'h2000,
    parameter logic [7:0]  RST_MONTH = 8'h01,
    parameter logic [7:0]  RST_DAY   = 8'h01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    input  logic        load,
    input  logic [15:0] ld_year,
    input  logic [7:0]  ld_month,
    input  logic [7:0]  ld_day,
    input  logic        LY,
    output logic [3:0]  YM,
    output logic [3:0]  YH,
    output logic [3:0]  YT,
    output logic [3:0]  YO,
    output logic [3:0]  MT,
    output logic [3:0]  MO,
    output logic [3:0]  DT,
    output logic [3:0]  DO,
    output logic        busy,
    output logic        load_err,
    output logic        wrap
);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_year, w_year_nxt, w_adv_year;
    logic [7:0]  r_month, w_month_nxt, w_adv_month;
    logic [7:0]  r_day, w_day_nxt, w_adv_day;
    logic        r_pending, w_pending_nxt;
    logic        r_load_err, w_load_err_nxt;
    logic        r_wrap, w_wrap_nxt, w_adv_wrap;
    logic [7:0]  w_cur_len, w_ld_len;
    logic        w_ld_ok;

    function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_ok(input logic [31:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    month_length u_len_cur (.i_month(r_month),  .i_ly(LY),   .o_len(w_cur_len));
    // Loads are screened with Feb as 29; a non-leap Feb 29 is clamped later in CHECK.
    month_length u_len_ld  (.i_month(ld_month), .i_ly(1'b1), .o_len(w_ld_len));

    assign w_ld_ok = bcd_ok({ld_year, ld_month, ld_day})
                   && (ld_month >= M_JAN) && (ld_month <= M_DEC)
                   && (ld_day != 8'h00) && (ld_day <= w_ld_len);

    // Valid BCD compares correctly as plain binary, so day < len needs no digit split.
    always_comb begin
        w_adv_year  = r_year;
        w_adv_month = r_month;
        w_adv_day   = r_day;
        w_adv_wrap  = 1'b0;
        if (r_day < w_cur_len) begin
            w_adv_day = bcd_inc8(r_day);
        end else begin
            w_adv_day = D_01;
            if (r_month == M_DEC) begin
                w_adv_month = M_JAN;
                w_adv_year  = bcd_inc16(r_year);
                w_adv_wrap  = (r_year == Y_MAX);
            end else begin
                w_adv_month = bcd_inc8(r_month);
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_year_nxt     = r_year;
        w_month_nxt    = r_month;
        w_day_nxt      = r_day;
        w_pending_nxt  = r_pending;
        w_load_err_nxt = 1'b0;
        w_wrap_nxt     = 1'b0;
        case (r_state)
            RUN: begin
                if (load) begin
                    if (!w_ld_ok) begin
                        w_load_err_nxt = 1'b1;
                    end else begin
                        w_year_nxt  = ld_year;
                        w_month_nxt = ld_month;
                        w_day_nxt   = ld_day;
                        if (adv) w_pending_nxt = 1'b1;
                        if (ld_month == M_FEB && ld_day == D_29) w_state_nxt = CHECK;
                    end
                end else if (r_pending || adv) begin
                    w_year_nxt    = w_adv_year;
                    w_month_nxt   = w_adv_month;
                    w_day_nxt     = w_adv_day;
                    w_wrap_nxt    = w_adv_wrap;
                    w_pending_nxt = 1'b0;
                end
            end
            CHECK: begin
                w_state_nxt = RUN;
                if (adv) w_pending_nxt = 1'b1;
                if (!LY) begin
                    w_day_nxt      = D_28;
                    w_load_err_nxt = 1'b1;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_year     <= RST_YEAR;
            r_month    <= RST_MONTH;
            r_day      <= RST_DAY;
            r_pending  <= 1'b0;
            r_load_err <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_year     <= w_year_nxt;
            r_month    <= w_month_nxt;
            r_day      <= w_day_nxt;
            r_pending  <= w_pending_nxt;
            r_load_err <= w_load_err_nxt;
            r_wrap     <= w_wrap_nxt;
        end
    end

    assign {YM, YH, YT, YO} = r_year;
    assign {MT, MO}         = r_month;
    assign {DT, DO}         = r_day;
    assign busy             = (r_state == CHECK);
    assign load_err         = r_load_err;
    assign wrap             = r_wrap;

endmodule

// File: tb/tb_bcd_date_counter.sv
// tb/tb_bcd_date_counter.sv - self-checking bench for bcd_date_counter with a LeapYear model
module tb_bcd_date_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        adv = 1'b0;
    logic        load = 1'b0;
    logic [15:0] ld_year = 16'h0;
    logic [7:0]  ld_month = 8'h0;
    logic [7:0]  ld_day = 8'h0;
    logic        LY;
    logic [3:0]  YM, YH, YT, YO, MT, MO, DT, DO;
    logic        busy, load_err, wrap;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_date_counter dut (
        .clk(clk), .rst_n(rst_n), .adv(adv), .load(load),
        .ld_year(ld_year), .ld_month(ld_month), .ld_day(ld_day), .LY(LY),
        .YM(YM), .YH(YH), .YT(YT), .YO(YO), .MT(MT), .MO(MO), .DT(DT), .DO(DO),
        .busy(busy), .load_err(load_err), .wrap(wrap)
    );

    function automatic int is_leap(input int y);
        return ((y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0))) ? 1 : 0;
    endfunction

    function automatic logic leap_of(input logic [3:0] a, b, c, d);
        int y;
        y = int'(a) * 1000 + int'(b) * 100 + int'(c) * 10 + int'(d);
        return is_leap(y) != 0;
    endfunction

    assign LY = leap_of(YM, YH, YT, YO);

    function automatic int days_in(input int m, input int y);
        case (m)
            2:             return is_leap(y) != 0 ? 29 : 28;
            4, 6, 9, 11:   return 30;
            default:       return 31;
        endcase
    endfunction

    function automatic logic [15:0] bcd16(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] bcd8(input int v);
        return {4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    typedef struct packed {
        logic [15:0] y;
        logic [7:0]  m;
        logic [7:0]  d;
        logic        b;
        logic        e;
        logic        w;
    } exp_t;

    typedef struct {
        logic        adv;
        logic        load;
        logic [15:0] ly;
        logic [7:0]  lm;
        logic [7:0]  ld;
        exp_t        ex;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    function automatic vec_t mk(input logic a, input logic l, input logic [15:0] ly,
                                input logic [7:0] lm, input logic [7:0] ld,
                                input logic [15:0] ey, input logic [7:0] em, input logic [7:0] ed,
                                input logic eb, input logic ee, input logic ew);
        vec_t v;
        v.adv = a; v.load = l; v.ly = ly; v.lm = lm; v.ld = ld;
        v.ex = {ey, em, ed, eb, ee, ew};
        return v;
    endfunction

    task automatic check(input string tag);
        exp_t x, a;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        x = sb.pop_front();
        a = {YM, YH, YT, YO, MT, MO, DT, DO, busy, load_err, wrap};
        if (a !== x) begin
            n_bad++;
            $display("FAIL %s: got %h-%h-%h busy=%b err=%b wrap=%b, expected %h-%h-%h busy=%b err=%b wrap=%b",
                     tag, a.y, a.m, a.d, a.b, a.e, a.w, x.y, x.m, x.d, x.b, x.e, x.w);
        end
    endtask

    task automatic step(input string tag, input vec_t v);
        adv = v.adv; load = v.load;
        ld_year = v.ly; ld_month = v.lm; ld_day = v.ld;
        sb.push_back(v.ex);
        @(posedge clk);
        #1;
        check(tag);
        adv = 1'b0; load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int my, mm, md;

        // Day/month walk and leap handling
        tbl.push_back(mk(0, 1, 16'h1900, 8'h02, 8'h28, 16'h1900, 8'h02, 8'h28, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0,    8'h0,  8'h0,  16'h1900, 8'h03, 8'h01, 0, 0, 0));
        tbl.push_back(mk(0, 1, 16'h1900, 8'h02, 8'h29, 16'h1900, 8'h02, 8'h29, 1, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0,    8'h0,  8'h0,  16'h1900, 8'h02, 8'h28, 0, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0,    8'h0,  8'h0,  16'h1900, 8'h02, 8'h28, 0, 0, 0));
        tbl.push_back(mk(0, 1, 16'h2004, 8'h02, 8'h29, 16'h2004, 8'h02, 8'h29, 1, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0,    8'h0,  8'h0,  16'h2004, 8'h02, 8'h29, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0,    8'h0,  8'h0,  16'h2004, 8'h03, 8'h01, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0,    8'h0,  8'h0,  16'h2004, 8'h03, 8'h01, 0, 0, 0));
        // Year rollover and year 0000 as leap
        tbl.push_back(mk(0, 1, 16'h9999, 8'h12, 8'h31, 16'h9999, 8'h12, 8'h31, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0,    8'h0,  8'h0,  16'h0000, 8'h01, 8'h01, 0, 0, 1));
        tbl.push_back(mk(0, 0, 16'h0,    8'h0,  8'h0,  16'h0000, 8'h01, 8'h01, 0, 0, 0));
        tbl.push_back(mk(0, 1, 16'h0000, 8'h02, 8'h28, 16'h0000, 8'h02, 8'h28, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0,    8'h0,  8'h0,  16'h0000, 8'h02, 8'h29, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0,    8'h0,  8'h0,  16'h0000, 8'h03, 8'h01, 0, 0, 0));
        // Rejected loads leave the date alone
        tbl.push_back(mk(0, 1, 16'h2023, 8'h13, 8'h01, 16'h0000, 8'h03, 8'h01, 0, 1, 0));
        tbl.push_back(mk(1, 1, 16'h2023, 8'h01, 8'h1A, 16'h0000, 8'h03, 8'h01, 0, 1, 0));
        tbl.push_back(mk(0, 1, 16'h2023, 8'h04, 8'h31, 16'h0000, 8'h03, 8'h01, 0, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0,    8'h0,  8'h0,  16'h0000, 8'h03, 8'h01, 0, 0, 0));
        tbl.push_back(mk(0, 1, 16'h2023, 8'h00, 8'h05, 16'h0000, 8'h03, 8'h01, 0, 1, 0));
        tbl.push_back(mk(0, 1, 16'h2023, 8'h05, 8'h00, 16'h0000, 8'h03, 8'h01, 0, 1, 0));
        tbl.push_back(mk(0, 1, 16'h20A3, 8'h05, 8'h05, 16'h0000, 8'h03, 8'h01, 0, 1, 0));
        // Accepted load with coincident adv applies one deferred advance
        tbl.push_back(mk(1, 1, 16'h2023, 8'h04, 8'h30, 16'h2023, 8'h04, 8'h30, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0,    8'h0,  8'h0,  16'h2023, 8'h05, 8'h01, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0,    8'h0,  8'h0,  16'h2023, 8'h05, 8'h01, 0, 0, 0));

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sb.push_back({16'h2000, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0});
        check("reset_state");
        rst_n = 1'b1;

        my = 2000; mm = 1; md = 1;
        for (int i = 0; i < 60; i++) begin
            if (md < days_in(mm, my)) begin
                md++;
            end else begin
                md = 1;
                if (mm == 12) begin mm = 1; my = (my + 1) % 10000; end
                else mm++;
            end
            step($sformatf("walk_%0d", i + 1),
                 mk(1, 0, 16'h0, 8'h0, 8'h0, bcd16(my), bcd8(mm), bcd8(md), 0, 0, 0));
        end

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec_%0d", i), tbl[i]);
        end

        // Reset asserted while in CHECK with a pending advance requested
        step("rst_chk_load", mk(0, 1, 16'h1900, 8'h02, 8'h29, 16'h1900, 8'h02, 8'h29, 1, 0, 0));
        adv = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        sb.push_back({16'h2000, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0});
        check("rst_chk_async");
        @(posedge clk);
        #1;
        adv = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("rst_chk_after1", mk(0, 0, 16'h0, 8'h0, 8'h0, 16'h2000, 8'h01, 8'h01, 0, 0, 0));
        step("rst_chk_after2", mk(0, 0, 16'h0, 8'h0, 8'h0, 16'h2000, 8'h01, 8'h01, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
